// File: rtl/prng_share_ctrl.sv
// Shares one 32-bit Fibonacci LFSR between NUM_REQ requesters through a
// round-robin arbiter; every grant hands out one fresh word.
module prng_share_ctrl #(
    parameter int unsigned NUM_REQ    = 4,
    parameter logic [31:0] SEED       = 32'h00BD4410,
    parameter int unsigned WARMUP_CYC = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               seed_valid_i,
    input  logic [31:0]        seed_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               rnd_valid_o,
    output logic [31:0]        rnd_o,
    output logic               busy_o
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam logic [7:0]  WCNT_END = 8'(WARMUP_CYC);

    typedef enum logic {
        ST_WARMUP,
        ST_SERVE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [31:0]        lfsr_q, lfsr_d, lfsr_step, seed_eff, rnd_d;
    logic [PW-1:0]      rr_q, rr_d, winner, rr_after_win;
    logic [NUM_REQ-1:0] eligible, gnt_d;
    logic               found, valid_d;
    int unsigned        idx;

    assign lfsr_step = {lfsr_q[30:0],
                        lfsr_q[27] ^ lfsr_q[23] ^ lfsr_q[19] ^ lfsr_q[18] ^ lfsr_q[15] ^
                        lfsr_q[11] ^ lfsr_q[7]  ^ lfsr_q[4]  ^ lfsr_q[1]};

    // A zero seed would lock the LFSR, so it is replaced by the reset seed.
    assign seed_eff = (seed_i == '0) ? SEED : seed_i;

    assign busy_o = (state_q == ST_WARMUP);

    // Last cycle's grantee is masked so a still-held request cannot win twice.
    always_comb begin
        eligible = req_i & ~gnt_o;
        found    = 1'b0;
        winner   = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
        rr_after_win = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        lfsr_d  = lfsr_q;
        rr_d    = rr_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        rnd_d   = rnd_o;
        if (seed_valid_i) begin
            lfsr_d  = seed_eff;
            state_d = ST_WARMUP;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (wcnt_q == WCNT_END) begin
                        state_d = ST_SERVE;
                    end else begin
                        lfsr_d = lfsr_step;
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                ST_SERVE: begin
                    if (found) begin
                        gnt_d[winner] = 1'b1;
                        valid_d       = 1'b1;
                        rnd_d         = lfsr_q;
                        lfsr_d        = lfsr_step;
                        rr_d          = rr_after_win;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_WARMUP;
            wcnt_q      <= '0;
            lfsr_q      <= SEED;
            rr_q        <= '0;
            gnt_o       <= '0;
            rnd_valid_o <= 1'b0;
            rnd_o       <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            lfsr_q      <= lfsr_d;
            rr_q        <= rr_d;
            gnt_o       <= gnt_d;
            rnd_valid_o <= valid_d;
            rnd_o       <= rnd_d;
        end
    end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Scoreboard bench for prng_share_ctrl: directed scenarios push expected grants,
// monitors pop and compare whenever a DUT presents a grant.
module tb_prng_share_ctrl;

    localparam logic [31:0] SEED = 32'h00BD4410;
    localparam logic [31:0] TAPS = 32'h088C8892;  // bits 27,23,19,18,15,11,7,4,1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with default warm-up
    logic        reset_i, seed_valid_i, rnd_valid_o, busy_o;
    logic [31:0] seed_i, rnd_o;
    logic [3:0]  req_i, gnt_o;
    // DUT with zero warm-up
    logic        r0, sv0, v0, busy0;
    logic [31:0] seed0, rnd0;
    logic [3:0]  req0, gnt0;

    prng_share_ctrl #(.NUM_REQ(4), .SEED(SEED), .WARMUP_CYC(8)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .req_i(req_i), .gnt_o(gnt_o), .rnd_valid_o(rnd_valid_o), .rnd_o(rnd_o),
        .busy_o(busy_o));

    prng_share_ctrl #(.NUM_REQ(4), .SEED(SEED), .WARMUP_CYC(0)) u_dut0 (
        .clk_i(clk), .reset_i(r0), .seed_valid_i(sv0), .seed_i(seed0),
        .req_i(req0), .gnt_o(gnt0), .rnd_valid_o(v0), .rnd_o(rnd0),
        .busy_o(busy0));

    typedef struct {
        int unsigned cyc;
        logic [3:0]  gnt;
        logic [31:0] rnd;
    } exp_t;

    exp_t        q_main[$];
    exp_t        q_w0[$];
    exp_t        me, e0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] mdl;
    logic [31:0] rmdl;
    bit          rand_mode = 1'b0;
    bit          w0_done = 1'b0;
    bit          seen[bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return {v[30:0], ^(v & TAPS)};
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = nxt(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_gnt(input int unsigned c, input logic [3:0] g);
        q_main.push_back(exp_t'{c, g, mdl});
        mdl = nxt(mdl);
    endtask

    // Main monitor
    always @(negedge clk) begin
        if (rnd_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            if (rand_mode) begin
                check("rand_onehot", 32'($onehot(gnt_o)), 32'd1);
                check("rand_valid", 32'(rnd_valid_o), 32'd1);
                check("rand_word", rnd_o, rmdl);
                check("rand_unique", 32'(seen.exists(rnd_o)), 32'd0);
                seen[rnd_o] = 1'b1;
                rmdl = nxt(rmdl);
            end else if (q_main.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL main_unexpected_gnt: actual gnt=%b valid=%b required no grant (cycle %0d)",
                         gnt_o, rnd_valid_o, cyc);
            end else begin
                me = q_main.pop_front();
                check("main_gnt_cycle", cyc, me.cyc);
                check("main_gnt", 32'(gnt_o), 32'(me.gnt));
                check("main_valid", 32'(rnd_valid_o), 32'd1);
                check("main_rnd", rnd_o, me.rnd);
            end
        end
    end

    // Zero-warm-up monitor
    always @(negedge clk) begin
        if (v0 !== 1'b0 || gnt0 !== 4'b0000) begin
            if (q_w0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL w0_unexpected_gnt: actual gnt=%b valid=%b required no grant (cycle %0d)",
                         gnt0, v0, cyc);
            end else begin
                e0 = q_w0.pop_front();
                check("w0_gnt_cycle", cyc, e0.cyc);
                check("w0_gnt", 32'(gnt0), 32'(e0.gnt));
                check("w0_valid", 32'(v0), 32'd1);
                check("w0_rnd", rnd0, e0.rnd);
            end
        end
    end

    // Zero warm-up: held single request is granted every other cycle
    initial begin
        int unsigned c;
        r0 = 1'b1; sv0 = 1'b0; seed0 = '0; req0 = '0;
        tick(); tick();
        check("w0_reset_busy", 32'(busy0), 32'd1);
        r0   = 1'b0;
        req0 = 4'b0001;
        c    = cyc;
        q_w0.push_back(exp_t'{c + 2, 4'b0001, 32'h00BD4410});
        q_w0.push_back(exp_t'{c + 4, 4'b0001, 32'h017A8820});
        q_w0.push_back(exp_t'{c + 6, 4'b0001, nxt(32'h017A8820)});
        tick();
        check("w0_busy_after_first_edge", 32'(busy0), 32'd0);
        repeat (5) tick();
        req0 = '0;
        tick(); tick();
        w0_done = 1'b1;
    end

    initial begin
        int unsigned c;
        reset_i = 1'b1; seed_valid_i = 1'b0; seed_i = '0; req_i = '0;
        tick(); tick();
        check("reset_gnt", 32'(gnt_o), 32'd0);
        check("reset_valid", 32'(rnd_valid_o), 32'd0);
        check("reset_rnd", rnd_o, 32'd0);
        check("reset_busy", 32'(busy_o), 32'd1);

        // Warm-up after reset release
        reset_i = 1'b0;
        mdl     = adv(SEED, 8);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("warmup_busy", 32'(busy_o), 32'd1);
        end
        tick();
        check("serve_not_busy", 32'(busy_o), 32'd0);

        // All requesters held: back-to-back rotation
        req_i = 4'b1111;
        c     = cyc;
        for (int i = 0; i < 8; i++) expect_gnt(c + 1 + i, 4'(1 << (i % 4)));
        repeat (8) tick();
        req_i = '0;

        // Reseed with zero while a request is pending
        c            = cyc;
        req_i        = 4'b0100;
        seed_valid_i = 1'b1;
        seed_i       = '0;
        tick();
        seed_valid_i = 1'b0;
        check("reseed_no_gnt", 32'(gnt_o), 32'd0);
        check("reseed_busy", 32'(busy_o), 32'd1);
        mdl = adv(SEED, 8);
        expect_gnt(c + 11, 4'b0100);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("reseed_warmup_busy", 32'(busy_o), 32'd1);
        end
        tick();
        check("reseed_serve_not_busy", 32'(busy_o), 32'd0);
        tick();
        req_i = '0;

        // Non-zero reseed, then two requesters with pointer wrap
        c            = cyc;
        seed_valid_i = 1'b1;
        seed_i       = 32'hDEADBEEF;
        tick();
        seed_valid_i = 1'b0;
        seed_i       = '0;
        mdl          = adv(32'hDEADBEEF, 8);
        repeat (9) tick();
        req_i = 4'b0011;
        expect_gnt(c + 11, 4'b0001);
        expect_gnt(c + 12, 4'b0010);
        expect_gnt(c + 13, 4'b0001);
        expect_gnt(c + 14, 4'b0010);
        repeat (4) tick();
        req_i = '0;

        // Asynchronous reset while a grant is on the outputs
        c     = cyc;
        req_i = 4'b1000;
        expect_gnt(c + 1, 4'b1000);
        tick();
        req_i = '0;
        @(negedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt_o), 32'd0);
        check("async_rst_valid", 32'(rnd_valid_o), 32'd0);
        check("async_rst_rnd", rnd_o, 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd1);
        tick(); tick();
        reset_i = 1'b0;
        mdl     = adv(SEED, 8);
        repeat (9) tick();
        c     = cyc;
        req_i = 4'b0001;
        expect_gnt(c + 1, 4'b0001);
        tick();
        req_i = '0;
        tick();

        // Random requests: one-hot grants, model-exact and unique words
        rmdl      = mdl;
        rand_mode = 1'b1;
        repeat (2000) begin
            req_i = 4'($urandom_range(0, 15));
            tick();
        end
        req_i = '0;
        tick(); tick();
        rand_mode = 1'b0;

        for (int i = 0; i < 100 && !w0_done; i++) tick();
        check("w0_finished", 32'(w0_done), 32'd1);
        check("main_queue_drained", 32'(q_main.size()), 32'd0);
        check("w0_queue_drained", 32'(q_w0.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
